// File: rtl/ccc_div_pkg.sv
// Shared lock-FSM states, ratio type and special ratio values for ccc_clk_div.
// Declarations only; no latency and no flow control.
package ccc_div_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCK = 2'd0,
      ST_FILTER = 2'd1,
      ST_RUN    = 2'd2
   } lock_state_t;

   localparam int DIV_W_DEF = 8;

   typedef logic [DIV_W_DEF-1:0] ratio_t;

   // A ratio of 0 parks the channel; a ratio of 1 makes CE a constant high.
   localparam ratio_t DIV_OFF  = ratio_t'(0);
   localparam ratio_t DIV_PASS = ratio_t'(1);

   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ccc_div_chan.sv
// One clock-enable channel: ratio shadow, period counter and registered CE pulse.
// CE is a flop output; the channel is free-running with no backpressure.
module ccc_div_chan
   import ccc_div_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_run,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_ce
);

   localparam logic [DIV_W-1:0] C_OFF  = DIV_W'(DIV_OFF);
   localparam logic [DIV_W-1:0] C_PASS = DIV_W'(DIV_PASS);
   localparam logic [DIV_W-1:0] C_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_ratio;
   logic             r_act;
   logic             r_ce;

   logic             w_act;
   logic [DIV_W-1:0] w_cnt_inc;
   logic [DIV_W-1:0] w_last;

   // i_run is the lock FSM's next state, so r_cnt and r_ce describe the cycle being entered.
   assign w_act     = i_run & i_en;
   assign w_cnt_inc = r_cnt + C_ONE;
   assign w_last    = r_ratio - C_ONE;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_ratio <= '0;
         r_act   <= 1'b0;
         r_ce    <= 1'b0;
      end else begin
         r_act <= w_act;
         if (!w_act) begin
            r_cnt   <= '0;
            r_ratio <= i_div;
            r_ce    <= 1'b0;
         end else if (!r_act || (r_ratio == C_OFF)) begin
            r_cnt   <= '0;
            r_ratio <= i_div;
            r_ce    <= (i_div == C_PASS) && !i_sync;
         end else if (i_sync) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
         end else if (r_cnt == w_last) begin
            r_cnt   <= '0;
            r_ratio <= i_div;
            r_ce    <= (i_div == C_PASS);
         end else begin
            r_cnt <= w_cnt_inc;
            r_ce  <= (w_cnt_inc == w_last);
         end
      end
   end

   assign o_ce = r_ce;

endmodule

// File: rtl/ccc_clk_div.sv
// PLL lock filter plus NUM_CH phase-aligned clock-enable dividers; LOCK has 2-cycle sync latency.
// All outputs registered, no backpressure; SYNC realignment only with CCC_DIV_ALIGN_EN defined.
module ccc_clk_div
   import ccc_div_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DIV_W     = DIV_W_DEF,
   parameter int LOCK_FILT = 256
) (
   input  logic                    CLK,
   input  logic                    ARST,
   input  logic                    LOCK,
   input  logic [NUM_CH*DIV_W-1:0] DIV,
   input  logic [NUM_CH-1:0]       CH_EN,
   input  logic                    SYNC,
   output logic                    LOCKED,
   output logic                    RST_OUT,
   output logic [NUM_CH-1:0]       CE
);

   localparam int               FILT_W    = cnt_width(LOCK_FILT);
   localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 2);

   logic              r_lock_s1;
   logic              r_lock_s2;
   lock_state_t       r_state;
   logic [FILT_W-1:0] r_filt_cnt;
   logic              r_locked;
   logic              r_rst_out;

   lock_state_t       w_state_nxt;
   logic [FILT_W-1:0] w_filt_nxt;
   logic              w_run_nxt;
   logic              w_sync;

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         r_lock_s1  <= 1'b0;
         r_lock_s2  <= 1'b0;
         r_state    <= ST_UNLOCK;
         r_filt_cnt <= '0;
         r_locked   <= 1'b0;
         r_rst_out  <= 1'b1;
      end else begin
         r_lock_s1  <= LOCK;
         r_lock_s2  <= r_lock_s1;
         r_state    <= w_state_nxt;
         r_filt_cnt <= w_filt_nxt;
         r_locked   <= w_run_nxt;
         r_rst_out  <= !w_run_nxt;
      end
   end

   // RUN is entered on the edge where the filter count becomes LOCK_FILT-1; loss of lock is not filtered.
   always_comb begin
      w_state_nxt = r_state;
      w_filt_nxt  = r_filt_cnt;
      case (r_state)
         ST_UNLOCK: begin
            if (r_lock_s2) begin
               w_state_nxt = ST_FILTER;
               w_filt_nxt  = '0;
            end
         end
         ST_FILTER: begin
            if (!r_lock_s2) begin
               w_state_nxt = ST_UNLOCK;
            end else begin
               w_filt_nxt = r_filt_cnt + FILT_ONE;
               if (r_filt_cnt == FILT_LAST) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (!r_lock_s2) begin
               w_state_nxt = ST_UNLOCK;
            end
         end
         default: begin
            w_state_nxt = ST_UNLOCK;
         end
      endcase
   end

   assign w_run_nxt = (w_state_nxt == ST_RUN);

`ifdef CCC_DIV_ALIGN_EN
   assign w_sync = SYNC;
`else
   logic w_sync_unused;
   assign w_sync_unused = SYNC;
   assign w_sync        = 1'b0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      ccc_div_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .i_clk  (CLK),
         .i_rst  (ARST),
         .i_run  (w_run_nxt),
         .i_en   (CH_EN[g]),
         .i_sync (w_sync),
         .i_div  (DIV[g*DIV_W +: DIV_W]),
         .o_ce   (CE[g])
      );
   end

   assign LOCKED  = r_locked;
   assign RST_OUT = r_rst_out;

endmodule

// File: tb/tb_ccc_clk_div.sv
// Self-checking bench for ccc_clk_div: lock filter timing, divider schedules, lock loss, async reset.
module tb_ccc_clk_div;

   logic        clk;
   logic        arst;
   logic        lock;
   logic [31:0] div;
   logic [3:0]  ch_en;
   logic        sync;
   logic        locked;
   logic        rst_out;
   logic [3:0]  ce;

   int checks   = 0;
   int failures = 0;

   logic [3:0] sb_q[$];

   typedef struct {
      logic [7:0] div;
      int         first;
      int         period;
      int         ncyc;
   } vec_t;

   vec_t vecs[7];

`ifdef CCC_DIV_ALIGN_EN
   localparam int SYNC_K = 7;
`else
   localparam int SYNC_K = 1000;
`endif

   ccc_clk_div #(
      .NUM_CH    (4),
      .DIV_W     (8),
      .LOCK_FILT (256)
   ) dut (
      .CLK     (clk),
      .ARST    (arst),
      .LOCK    (lock),
      .DIV     (div),
      .CH_EN   (ch_en),
      .SYNC    (sync),
      .LOCKED  (locked),
      .RST_OUT (rst_out),
      .CE      (ce)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_step(input string name, input logic [3:0] exp);
      sb_q.push_back(exp);
      tick();
      chk(name, {28'd0, ce}, {28'd0, sb_q.pop_front()});
   endtask

   // Channel config {ch3=3, ch2=0, ch1=1, ch0=5}; ch0 switches to 3 at k=26, ch3 off for k in [40,50).
   function automatic logic [3:0] exp_c(input int k);
      logic [3:0] e;
      e    = '0;
      e[0] = (k <= 29) ? ((k + 1) % 5 == 0) : ((k - 29) % 3 == 0);
      e[1] = 1'b1;
      e[2] = 1'b0;
      e[3] = (k < 40) ? ((k + 1) % 3 == 0) : ((k < 50) ? 1'b0 : ((k - 49) % 3 == 0));
      return e;
   endfunction

   // Channel config {ch3=3, ch2=1, ch1=6, ch0=4}; a SYNC taking effect at cycle sk restarts all phases.
   function automatic logic [3:0] exp_g(input int k, input int sk);
      logic [3:0] e;
      int         b;
      e = '0;
      b = (k >= sk) ? (k - sk + 1) : (k + 1);
      if (k == sk) return e;
      e[0] = (b % 4 == 0);
      e[1] = (b % 6 == 0);
      e[2] = 1'b1;
      e[3] = (b % 3 == 0);
      return e;
   endfunction

   initial begin
      vecs[0] = '{8'd1,   1,   1,   5};
      vecs[1] = '{8'd2,   2,   2,   8};
      vecs[2] = '{8'd3,   3,   3,   9};
      vecs[3] = '{8'd5,   5,   5,  12};
      vecs[4] = '{8'd7,   7,   7,  15};
      vecs[5] = '{8'd0,   0,   0,  10};
      vecs[6] = '{8'd255, 255, 255, 258};

      arst  = 1'b1;
      lock  = 1'b0;
      div   = {8'd3, 8'd0, 8'd1, 8'd5};
      ch_en = 4'b1111;
      sync  = 1'b0;
      repeat (3) tick();
      chk("reset_locked", {31'd0, locked}, 32'd0);
      chk("reset_rst_out", {31'd0, rst_out}, 32'd1);
      chk("reset_ce", {28'd0, ce}, 32'd0);

      arst = 1'b0;
      lock = 1'b1;
      for (int n = 1; n <= 258; n++) begin
         tick();
         if (n == 257) begin
            chk("lock_257_locked", {31'd0, locked}, 32'd0);
            chk("lock_257_rst_out", {31'd0, rst_out}, 32'd1);
            chk("lock_257_ce", {28'd0, ce}, 32'd0);
         end
         if (n == 258) begin
            chk("lock_258_locked", {31'd0, locked}, 32'd1);
            chk("lock_258_rst_out", {31'd0, rst_out}, 32'd0);
         end
      end
      chk("ce_align_k0", {28'd0, ce}, {28'd0, exp_c(0)});

      for (int k = 1; k < 60; k++) begin
         if (k == 26) div[7:0] = 8'd3;
         if (k == 40) ch_en[3] = 1'b0;
         if (k == 50) ch_en[3] = 1'b1;
         sb_step("ce_align", exp_c(k));
      end

      ch_en = 4'b0001;
      for (int r = 0; r < 7; r++) begin
         div[7:0] = vecs[r].div;
         ch_en[0] = 1'b0;
         tick();
         chk("tbl_idle_ce", {28'd0, ce}, 32'd0);
         ch_en[0] = 1'b1;
         for (int c = 1; c <= vecs[r].ncyc; c++) begin
            sb_step("ce_tbl",
               ((vecs[r].period != 0) && (c >= vecs[r].first) &&
                ((c - vecs[r].first) % vecs[r].period == 0)) ? 4'b0001 : 4'b0000);
         end
      end

      div   = {8'd3, 8'd0, 8'd1, 8'd5};
      ch_en = 4'b1111;
      repeat (3) tick();
      chk("pre_drop_ce1", {31'd0, ce[1]}, 32'd1);
      lock = 1'b0;
      tick();
      chk("drop_e1_locked", {31'd0, locked}, 32'd1);
      tick();
      chk("drop_e2_locked", {31'd0, locked}, 32'd1);
      tick();
      chk("drop_e3_locked", {31'd0, locked}, 32'd0);
      chk("drop_e3_rst_out", {31'd0, rst_out}, 32'd1);
      chk("drop_e3_ce", {28'd0, ce}, 32'd0);
      repeat (5) tick();
      chk("drop_late_ce", {28'd0, ce}, 32'd0);

      div  = {8'd3, 8'd1, 8'd6, 8'd4};
      lock = 1'b1;
      repeat (100) tick();
      lock = 1'b0;
      tick();
      lock = 1'b1;
      for (int m = 1; m <= 258; m++) begin
         tick();
         if (m == 157) chk("glitch_orig_run_locked", {31'd0, locked}, 32'd0);
         if (m == 257) begin
            chk("glitch_257_locked", {31'd0, locked}, 32'd0);
            chk("glitch_257_rst_out", {31'd0, rst_out}, 32'd1);
         end
         if (m == 258) begin
            chk("glitch_258_locked", {31'd0, locked}, 32'd1);
            chk("glitch_258_rst_out", {31'd0, rst_out}, 32'd0);
         end
      end
      chk("ce_sync_k0", {28'd0, ce}, {28'd0, exp_g(0, SYNC_K)});
      for (int k = 1; k <= 30; k++) begin
         sync = (k == 7);
         sb_step("ce_sync", exp_g(k, SYNC_K));
      end
      sync = 1'b0;

      chk("pre_arst_locked", {31'd0, locked}, 32'd1);
      chk("pre_arst_ce2", {31'd0, ce[2]}, 32'd1);
      #3;
      arst = 1'b1;
      #1;
      chk("arst_async_locked", {31'd0, locked}, 32'd0);
      chk("arst_async_rst_out", {31'd0, rst_out}, 32'd1);
      chk("arst_async_ce", {28'd0, ce}, 32'd0);
      tick();
      chk("arst_hold_locked", {31'd0, locked}, 32'd0);
      chk("arst_hold_ce", {28'd0, ce}, 32'd0);
      arst = 1'b0;
      lock = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ccc_clk_div.md
CCC_CLK_DIV -- requirements
Module: ccc_clk_div

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, meaning divider ratio width per channel.
REQ-003 SHALL have parameter LOCK_FILT, default 256, meaning consecutive synchronised LOCK-high cycles required before LOCKED.
REQ-004 SHALL have port CLK  input  1  sole clock (PLL GL0 net); all logic on rising edge.
REQ-005 SHALL have port ARST  input  1  asynchronous active-high reset.
REQ-006 SHALL have port LOCK  input  1  raw PLL lock, asynchronous to CLK.
REQ-007 SHALL have port DIV  input  NUM_CH*DIV_W  per-channel ratio, channel i at bits [i*DIV_W +: DIV_W].
REQ-008 SHALL have port CH_EN  input  NUM_CH  per-channel enable.
REQ-009 SHALL have port SYNC  input  1  phase-align strobe (used only with CCC_DIV_ALIGN_EN).
REQ-010 SHALL have port LOCKED  output  1  filtered lock status.
REQ-011 SHALL have port RST_OUT  output  1  active-high synchronous downstream reset.
REQ-012 SHALL have port CE  output  NUM_CH  one-cycle clock-enable pulses.

Function
REQ-013 SHALL pass LOCK through a 2-flop synchroniser before any use (2-cycle latency).
REQ-014 SHALL implement lock FSM states UNLOCK, FILTER, RUN.
REQ-015 SHALL go UNLOCK->FILTER when synchronised lock is 1, clearing the filter counter.
REQ-016 SHALL, in FILTER, increment the filter counter each lock-high cycle and go to RUN when the count reaches LOCK_FILT-1.
REQ-017 SHALL go from FILTER or RUN to UNLOCK in the cycle after synchronised lock is 0 (no filtering on loss).
REQ-018 SHALL drive LOCKED=1 and RST_OUT=0 only in RUN; otherwise LOCKED=0, RST_OUT=1, all CE=0.
REQ-019 SHALL, per channel in RUN with CH_EN=1, count 0..DIV-1 and pulse CE on the cycle the count equals DIV-1, then wrap to 0.
REQ-020 SHALL treat DIV=0 as channel off (CE=0, counter held 0) and DIV=1 as CE constantly 1.
REQ-021 SHALL sample a new DIV value only at wrap, so a ratio change never shortens or glitches the current period.
REQ-022 SHALL hold the counter at 0 while CH_EN=0 and give the first CE DIV cycles after CH_EN rises.
REQ-023 SHALL restart all channel counters from 0 on the first RUN cycle, so CE phases are aligned at lock.
REQ-024 SHALL register all outputs (no combinational path from input to output).

Reset
REQ-025 SHALL, on ARST=1, immediately force FSM=UNLOCK, synchroniser, filter and channel counters to 0, LOCKED=0, RST_OUT=1, CE=0.
REQ-026 SHALL release ARST without glitch on outputs; first RUN is reachable no earlier than LOCK_FILT+2 cycles after release.
REQ-027 SHALL, on ARST or loss of lock mid-period, abandon the period with no trailing CE pulse.

Configuration
REQ-028 SHALL compile SYNC support only when macro CCC_DIV_ALIGN_EN is defined.
REQ-029 SHALL, with CCC_DIV_ALIGN_EN, reset every enabled channel counter to 0 in the cycle after SYNC=1 in RUN, suppressing CE in that cycle; SYNC has priority over wrap.
REQ-030 SHALL, without CCC_DIV_ALIGN_EN, ignore SYNC entirely and infer no logic from it.

Structure
REQ-031 SHALL place FSM state enum, the ratio typedef and the DIV=0/DIV=1 special-value constants in shared package ccc_div_pkg.
REQ-032 SHALL implement one channel (counter, ratio shadow register, CE flop) as sub-module ccc_div_chan, instantiated NUM_CH times by generate.

Verification
REQ-033 SHALL cover: LOCK=1 held from reset release, LOCK_FILT=256 -> LOCKED=1 and RST_OUT=0 exactly 258 cycles after LOCK rises, synchroniser included.
REQ-034 SHALL cover: LOCK glitch low 1 cycle during FILTER at count 100 -> return to UNLOCK and full 256-cycle refilter.
REQ-035 SHALL cover: DIV=5, CH_EN=1 in RUN -> CE every 5th cycle; DIV changed to 3 mid-period -> next period still 5, then period 3.
REQ-036 SHALL cover: DIV=0 -> CE never; DIV=1 -> CE high every RUN cycle; LOCK drop -> CE=0 and RST_OUT=1 within 3 cycles.
REQ-037 SHALL cover: with CCC_DIV_ALIGN_EN, ch0 DIV=4 and ch1 DIV=6 free-running, SYNC pulse -> both first CE 4 and 6 cycles later, coincident every 12.
REQ-038 SHALL cover: ARST asserted mid-period -> all outputs at reset values asynchronously, before the next CLK edge.
